// File: rtl/punch_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : punch_round_ctrl_if
// Description : Request/valid handshake between the punch-round controller
//               and its random target generator.
//   rnd_req  controller -> generator  request for a new target
//   rnd_vld  generator -> controller  rnd_val is valid this cycle
//   rnd_val  generator -> controller  target number, legal values 1..3
// Revision    : 1.0  initial release
// ============================================================================
interface punch_round_ctrl_if;
  logic       rnd_req;
  logic       rnd_vld;
  logic [1:0] rnd_val;

  modport master (output rnd_req, input rnd_vld, input rnd_val);
  modport slave  (input rnd_req, output rnd_vld, output rnd_val);
endinterface
`default_nettype wire

// File: rtl/punch_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : punch_round_ctrl
// Description : Reaction-game round controller. Each round fetches a random
//               target, lights it, scores a hit on a clean button edge or a
//               miss on wrong button / timeout, gives feedback, pauses, and
//               after ROUNDS rounds parks in DONE.
// Ports       :
//   clk      sole clock, rising edge
//   rst_n    asynchronous active-low reset
//   i_start  level, begins a game when sampled high in IDLE or DONE
//   i_btn    synchronized buttons, i_btn[k] hits target k+1
//   rnd      random generator handshake (master side)
//   o_led    [3:1] one-hot target, [0] hit feedback, 4'b1111 when done
//   o_score  hits this game (saturating)
//   o_miss   misses this game (saturating)
//   o_busy   high outside IDLE/DONE
//   o_done   high in DONE
// Revision    : 1.0  initial release
// ============================================================================
module punch_round_ctrl #(
  parameter int TICK_DIV      = 25000000,
  parameter int TIMEOUT_TICKS = 4,
  parameter int GAP_TICKS     = 1,
  parameter int ROUNDS        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [2:0]         i_btn,
  punch_round_ctrl_if.master rnd,
  output logic [3:0]         o_led,
  output logic [7:0]         o_score,
  output logic [7:0]         o_miss,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_SHOW = 3'd2;
  localparam logic [2:0] S_HIT  = 3'd3;
  localparam logic [2:0] S_MISS = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = 16;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [PW-1:0] r_presc;
  logic [CW-1:0] r_tcnt;
  logic [7:0]    r_round;
  logic [1:0]    r_target;
  logic [2:0]    r_btn_prev;
  logic [2:0]    w_edge;
  logic [2:0]    w_tmask;
  logic [3:0]    w_led;
  logic          w_tick;
  logic          w_hit;
  logic          w_wrong;
  logic          w_clear;
  logic          w_capture;
  logic          w_score_inc;
  logic          w_miss_inc;
  logic          w_round_inc;

  assign w_tick  = (r_presc == PW'(TICK_DIV - 1));
  assign w_edge  = i_btn & ~r_btn_prev;
  assign w_hit   = |(w_edge & w_tmask);
  // Any non-target edge is a miss, even when the target edge comes with it.
  assign w_wrong = |(w_edge & ~w_tmask);

  always_comb begin
    w_tmask = 3'b000;
    case (r_target)
      2'd1:    w_tmask = 3'b001;
      2'd2:    w_tmask = 3'b010;
      2'd3:    w_tmask = 3'b100;
      default: w_tmask = 3'b000;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_clear     = 1'b0;
    w_capture   = 1'b0;
    w_score_inc = 1'b0;
    w_miss_inc  = 1'b0;
    w_round_inc = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_clear = 1'b1;
          w_next  = S_REQ;
        end
      end
      S_REQ: begin
        // A valid zero is not a legal target; keep requesting.
        if (rnd.rnd_vld && (rnd.rnd_val != 2'd0)) begin
          w_capture = 1'b1;
          w_next    = S_SHOW;
        end
      end
      S_SHOW: begin
        // Button edges are evaluated before the timeout so a press in the
        // final cycle still counts.
        if (w_wrong) begin
          w_miss_inc = 1'b1;
          w_next     = S_MISS;
        end else if (w_hit) begin
          w_score_inc = 1'b1;
          w_next      = S_HIT;
        end else if (w_tick && (r_tcnt == CW'(TIMEOUT_TICKS - 1))) begin
          w_miss_inc = 1'b1;
          w_next     = S_MISS;
        end
      end
      S_HIT, S_MISS: begin
        if (w_tick) w_next = S_GAP;
      end
      S_GAP: begin
        if (w_tick && (r_tcnt == CW'(GAP_TICKS - 1))) begin
          w_round_inc = 1'b1;
          w_next      = ((r_round + 8'd1) == 8'(ROUNDS)) ? S_DONE : S_REQ;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_led = 4'b0000;
    case (r_state)
      S_SHOW:  w_led = {w_tmask, 1'b0};
      S_HIT:   w_led = 4'b0001;
      S_DONE:  w_led = 4'b1111;
      default: w_led = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_tcnt      <= '0;
      r_round     <= 8'd0;
      r_target    <= 2'd0;
      r_btn_prev  <= 3'b000;
      o_led       <= 4'b0000;
      o_score     <= 8'd0;
      o_miss      <= 8'd0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      rnd.rnd_req <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_btn_prev <= i_btn;

      // Prescaler and tick counter both restart on every state entry.
      if (w_next != r_state) begin
        r_presc <= '0;
        r_tcnt  <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_tcnt  <= r_tcnt + CW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      if (w_capture) r_target <= rnd.rnd_val;

      if (w_clear) begin
        o_score <= 8'd0;
        o_miss  <= 8'd0;
        r_round <= 8'd0;
      end
      if (w_score_inc && (o_score != 8'hFF)) o_score <= o_score + 8'd1;
      if (w_miss_inc && (o_miss != 8'hFF))   o_miss  <= o_miss + 8'd1;
      if (w_round_inc)                       r_round <= r_round + 8'd1;

      // Outputs follow the registered state, one cycle behind it.
      o_led       <= w_led;
      o_busy      <= (r_state != S_IDLE) && (r_state != S_DONE);
      o_done      <= (r_state == S_DONE);
      rnd.rnd_req <= (r_state == S_REQ);
    end
  end

endmodule
`default_nettype wire

// File: doc/punch_round_ctrl.md
PUNCH_ROUND_CTRL -- requirements
Module: punch_round_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 25000000, clk cycles per game tick (>=2).
REQ-002 Parameter TIMEOUT_TICKS, default 4, ticks a target stays lit before a miss is scored (>=1).
REQ-003 Parameter GAP_TICKS, default 1, ticks with target LEDs dark between rounds (>=1).
REQ-004 Parameter ROUNDS, default 16, rounds per game (1..255).
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  synchronous level; sampled high in IDLE or DONE begins a game.
REQ-008 btn  input  3  player buttons, already synchronized to clk, active-high level; btn[k] hits target k+1.
REQ-009 rnd_req  output  1  request to random generator.
REQ-010 rnd_vld  input  1  random value valid, may assert any cycle after rnd_req rises.
REQ-011 rnd_val  input  2  random target, legal values 1..3.
REQ-012 led  output  4  led[3:1] one-hot target, led[0] hit feedback.
REQ-013 score  output  8  hits this game.
REQ-014 miss  output  8  misses this game.
REQ-015 busy  output  1  high in every state except IDLE and DONE.
REQ-016 done  output  1  high in DONE only.

Function
REQ-017 States: IDLE, REQ, SHOW, HIT, MISS, GAP, DONE; encoding free.
REQ-018 Tick prescaler restarts at 0 on every state entry; tick pulses one cycle when it reaches TICK_DIV-1, then wraps to 0.
REQ-019 Button edge = btn[k] high and registered previous btn[k] low; previous-button register updates every cycle in every state.
REQ-020 IDLE/DONE: start high -> clear score, miss, round counter; next cycle REQ.
REQ-021 REQ: rnd_req high for every cycle in REQ; on rnd_vld high with rnd_val in 1..3, capture target, go SHOW; rnd_val==0 with rnd_vld ignored, stay REQ.
REQ-022 SHOW: led[target]=1, other led bits 0; counts ticks.
REQ-023 SHOW, edge on btn[target-1] only -> score+1, go HIT.
REQ-024 SHOW, any edge on a non-target button (including together with target edge) -> miss+1, go MISS.
REQ-025 SHOW, TIMEOUT_TICKS-th tick with no edge -> miss+1, go MISS; an edge in the timeout cycle takes precedence over timeout.
REQ-026 HIT: led=4'b0001 for one tick, then GAP. MISS: led=4'b0000 for one tick, then GAP.
REQ-027 GAP: led=0, button edges ignored; after GAP_TICKS ticks, round counter+1; if it equals ROUNDS go DONE, else REQ.
REQ-028 score and miss saturate at 255; counters only change in the cycle of the SHOW exit decision.
REQ-029 score+miss equals round counter after every GAP exit.
REQ-030 start ignored while busy.
REQ-031 DONE: led=4'b1111, score/miss held until next start.
REQ-032 All outputs registered; led changes the cycle after the state change.

Reset
REQ-033 rst low forces immediately, regardless of clk: state IDLE, led=0, score=0, miss=0, rnd_req=0, busy=0, done=0, prescaler=0, round counter=0, previous-button register=0.
REQ-034 Reset mid-game discards the round; no partial score update after rst releases.
REQ-035 After rst high, first start sample occurs on the first rising clk edge.

Verification (TICK_DIV=4, TIMEOUT_TICKS=2, GAP_TICKS=1, ROUNDS=3)
REQ-036 start pulse, rnd_vld with rnd_val=2 two cycles later -> rnd_req high 3 cycles, led=4'b0100, busy=1.
REQ-037 In SHOW with target 2, btn=3'b010 rising -> score=1, led=4'b0001 for 4 cycles, then led=0 for 4 cycles, rnd_req rises.
REQ-038 Target 3, btn=3'b101 rising same cycle -> miss=1, score unchanged, led=0.
REQ-039 Target 1, no buttons -> after 8 cycles in SHOW miss increments; btn held high from before SHOW entry produces no hit.
REQ-040 rnd_val=0 with rnd_vld, then rnd_val=1 -> stays REQ, then led=4'b0010.
REQ-041 Three rounds complete -> done=1, busy=0, led=4'b1111, score+miss=3; rst low mid-SHOW -> all outputs 0 asynchronously.
